// File: rtl/fm_pkg.sv
// Shared definitions for the FM operator bank.
//  - FM_DW / FM_PHASE_W : default sample and phase accumulator widths
//  - fm_state_e         : frame sequencer states
//  - sample_t / phase_t : convenience typedefs at the default widths
//  - sat()              : signed clamp of a 32-bit value to a w-bit two's complement range
package fm_pkg;
  localparam int FM_DW      = 16;
  localparam int FM_PHASE_W = 24;

  typedef enum logic [2:0] {IDLE, MAC, CAPT, PHASE, LUT, WRITE} fm_state_e;

  typedef logic signed [FM_DW-1:0] sample_t;
  typedef logic [FM_PHASE_W-1:0]   phase_t;

  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w-1)) - 32'sd1;
    lo = -(32'sd1 <<< (w-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/fm_sine_rom.sv
// Four-port full-cycle sine table, one-cycle registered read.
//  clk      in   clock
//  rd_addr  in   NPORTS x LUT_AW  phase-derived table index per port
//  rd_data  out  NPORTS x DW      sine sample, amplitude 2**(DW-1)-1, valid one cycle after rd_addr
// The table is built at elaboration from an integer Taylor series over one quarter wave,
// then mirrored into the other three quadrants so 0, +max, 0, -max land exactly on the
// quadrant boundaries.
module fm_sine_rom #(
  parameter int DW     = 16,
  parameter int LUT_AW = 10,
  parameter int NPORTS = 4
) (
  input  logic                           clk,
  input  logic [NPORTS-1:0][LUT_AW-1:0]  rd_addr,
  output logic [NPORTS-1:0][DW-1:0]      rd_data
);

  // sin(k/qn * pi/2) * amp, rounded; Q30 fixed point, Taylor series to x^19.
  function automatic longint quarter_sine(input int k, input int qn, input longint amp);
    longint x, term, sum, v;
    x    = (longint'(k) * 64'sd1686629713) / longint'(qn);
    term = x;
    sum  = x;
    for (int n = 1; n <= 9; n++) begin
      term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2*n) * (2*n+1));
      sum  = sum + term;
    end
    v = (sum * amp + (64'sd1 <<< 29)) >>> 30;
    if (v > amp) v = amp;
    if (v < 0)   v = 0;
    return v;
  endfunction

  localparam int Q = 2**(LUT_AW-2);

  logic [DW-1:0] tab [2**LUT_AW];

  for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_tab
    localparam int     QD  = g / Q;
    localparam int     RR  = g % Q;
    localparam int     KK  = (QD % 2 == 1) ? (Q - RR) : RR;
    localparam longint MAG = quarter_sine(KK, Q, longint'(2**(DW-1) - 1));
    localparam logic [DW-1:0] VAL = (QD >= 2) ? DW'(-MAG) : DW'(MAG);
    assign tab[g] = VAL;
  end

  logic [NPORTS-1:0][DW-1:0] rd_data_d, rd_data_q;

  always_comb begin
    rd_data_d = '0;
    for (int p = 0; p < NPORTS; p++) rd_data_d[p] = tab[rd_addr[p]];
  end

  always_ff @(posedge clk) rd_data_q <= rd_data_d;

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fm_operator_bank.sv
// Four-operator FM voice bank driving and consuming a 4-target routing multiply-add stage.
// Per accepted sample_tick: enable the multiply-add, capture its results, advance the phase
// accumulators with them, look up sines, write them back to routing_values, mix carriers.
//  clk, reset_n          clock, synchronous active-low reset
//  sample_tick           frame start strobe (accepted only in IDLE, else sets overrun)
//  freq_we/addr/data     live phase increment write, any state
//  carrier_mask          operators summed into audio_out
//  routing_target        multiply-add results, sampled in CAPT
//  routing_enable        multiply-add enable, high for MAC_LAT cycles
//  routing_values        operator sample register file (slots OP_BASE..OP_BASE+3 written)
//  audio_out/audio_valid mixed sample; valid pulses during WRITE, value then held
//  busy, overrun         frame in progress; sticky tick-while-busy flag
// Build option: define FM_OUT_SAT_EN to clamp the mix instead of wrapping it.
module fm_operator_bank import fm_pkg::*; #(
  parameter int DW        = FM_DW,
  parameter int VOICE_AW  = 4,
  parameter int OP_BASE   = 0,
  parameter int PHASE_W   = FM_PHASE_W,
  parameter int LUT_AW    = 10,
  parameter int MOD_SHIFT = 4,
  parameter int MAC_LAT   = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              sample_tick,
  input  logic                              freq_we,
  input  logic [1:0]                        freq_addr,
  input  logic [PHASE_W-1:0]                freq_data,
  input  logic [3:0]                        carrier_mask,
  input  logic [3:0][DW-1:0]                routing_target,
  output logic                              routing_enable,
  output logic [2**VOICE_AW-1:0][DW-1:0]    routing_values,
  output logic [DW-1:0]                     audio_out,
  output logic                              audio_valid,
  output logic                              busy,
  output logic                              overrun
);

  localparam int NOPS = 4;
  localparam int CW   = $clog2(MAC_LAT + 1);
  localparam int SW   = DW + 2;

  fm_state_e                       state_d, state_q;
  logic [CW-1:0]                   mac_cnt_d, mac_cnt_q;
  logic [NOPS-1:0][PHASE_W-1:0]    freq_d, freq_q;
  logic [NOPS-1:0][PHASE_W-1:0]    shadow_d, shadow_q;
  logic [NOPS-1:0][PHASE_W-1:0]    phase_d, phase_q;
  logic [NOPS-1:0][DW-1:0]         target_d, target_q;
  logic [2**VOICE_AW-1:0][DW-1:0]  rv_d, rv_q;
  logic [DW-1:0]                   audio_d, audio_q;
  logic                            overrun_d, overrun_q;

  logic [NOPS-1:0][LUT_AW-1:0]     rom_addr;
  logic [NOPS-1:0][DW-1:0]         sine;
  logic signed [SW-1:0]            mix_sum;
  logic [DW-1:0]                   mix_out;

  // Address always tracks the accumulators; data registered at the end of LUT is what WRITE uses.
  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < NOPS; i++) rom_addr[i] = phase_q[i][PHASE_W-1 -: LUT_AW];
  end

  fm_sine_rom #(.DW(DW), .LUT_AW(LUT_AW), .NPORTS(NOPS)) u_rom (
    .clk     (clk),
    .rd_addr (rom_addr),
    .rd_data (sine)
  );

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NOPS; i++)
      if (carrier_mask[i]) mix_sum = mix_sum + SW'(signed'(sine[i]));
`ifdef FM_OUT_SAT_EN
    mix_out = DW'(sat(32'(mix_sum), DW));
`else
    mix_out = mix_sum[DW-1:0];
`endif
  end

  always_comb begin
    state_d        = state_q;
    mac_cnt_d      = mac_cnt_q;
    freq_d         = freq_q;
    shadow_d       = shadow_q;
    phase_d        = phase_q;
    target_d       = target_q;
    rv_d           = rv_q;
    audio_d        = audio_q;
    overrun_d      = overrun_q;
    routing_enable = 1'b0;
    audio_valid    = 1'b0;
    busy           = (state_q != IDLE);

    if (freq_we) freq_d[freq_addr] = freq_data;
    // WRITE counts as busy, so a tick on the last frame cycle is dropped here too.
    if (sample_tick && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: if (sample_tick) begin
        state_d   = MAC;
        mac_cnt_d = '0;
        shadow_d  = freq_q;
      end
      MAC: begin
        routing_enable = 1'b1;
        if (mac_cnt_q == CW'(MAC_LAT - 1)) state_d = CAPT;
        else mac_cnt_d = mac_cnt_q + 1'b1;
      end
      CAPT: begin
        target_d = routing_target;
        state_d  = PHASE;
      end
      PHASE: begin
        for (int i = 0; i < NOPS; i++)
          phase_d[i] = phase_q[i] + shadow_q[i]
                     + (PHASE_W'(signed'(target_q[i])) << MOD_SHIFT);
        state_d = LUT;
      end
      LUT: state_d = WRITE;
      WRITE: begin
        audio_valid = 1'b1;
        audio_d     = mix_out;
        for (int i = 0; i < NOPS; i++) rv_d[VOICE_AW'(OP_BASE + i)] = sine[i];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mac_cnt_q <= '0;
      freq_q    <= '0;
      shadow_q  <= '0;
      phase_q   <= '0;
      target_q  <= '0;
      rv_q      <= '0;
      audio_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mac_cnt_q <= mac_cnt_d;
      freq_q    <= freq_d;
      shadow_q  <= shadow_d;
      phase_q   <= phase_d;
      target_q  <= target_d;
      rv_q      <= rv_d;
      audio_q   <= audio_d;
      overrun_q <= overrun_d;
    end
  end

  // The new mix is presented in the WRITE cycle alongside audio_valid, then held.
  assign audio_out      = (state_q == WRITE) ? mix_out : audio_q;
  assign routing_values = rv_q;
  assign overrun        = overrun_q;

endmodule
